cpu_fetch: RTL and testbench
============================

# cpu_fetch

Instruction fetch and sequencing unit for the single-issue LEGv8 CPU. It owns the program counter and requests instruction words from instruction memory. It presents each word to the control decoder and datapath, then computes the next PC from the branch control outputs (Branch, BranchZero, BranchNonZero) and the ALU zero flag once the datapath retires the instruction. It stops permanently on HALT.

## Interface
- PC_W, 64, program counter and instruction address width.
- RESET_PC, 0, PC value after reset; bits [1:0] must be 0.

- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin fetching from the current PC; honoured only in IDLE.
- imem_req  out  1  instruction memory read request.
- imem_addr  out  PC_W  read address, equal to pc.
- imem_ack  in  1  read complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  32  instruction word.
- inst_valid  out  1  inst holds a fetched instruction for decode.
- inst  out  32  latched instruction; inst[31:21] feeds the control decoder.
- inst_ready  in  1  decode/datapath accepts inst.
- retire_valid  in  1  datapath has finished the issued instruction; branch inputs are valid.
- Branch  in  1  unconditional branch.
- BranchZero  in  1  CBZ.
- BranchNonZero  in  1  CBNZ.
- zero  in  1  ALU zero flag for the retiring instruction.
- pc  out  PC_W  address of the current instruction.
- halted  out  1  HALT has been issued.
- icount  out  32  retired-instruction counter; wraps modulo 2^32.

## Operation
- States are IDLE, FETCH, ISSUE, EXEC and HALTED.
- **IDLE:** start=1 moves to FETCH.
- **FETCH:** imem_req=1 and imem_addr=pc, both held stable until imem_ack. On ack, imem_rdata is captured into inst and the state moves to ISSUE.
- **ISSUE:** inst_valid=1 and inst stays stable until inst_ready.
  - On the handshake, if inst[31:21]=11'h7FF (HALT), the state moves to HALTED.
  - Otherwise it moves to EXEC.
- **EXEC:** waits for retire_valid. On retire:
  - taken = Branch | (BranchZero & zero) | (BranchNonZero & ~zero).
  - Offset selection: if Branch=1, off = sext(inst[25:0]). Else if BranchZero or BranchNonZero is 1, off = sext(inst[23:5]). Branch has priority when several are asserted.
  - pc_next = taken ? pc + (off << 2) : pc + 4, with all arithmetic modulo 2^PC_W.
  - pc is updated to pc_next, icount increments, and the state returns to FETCH.
- **HALTED:** terminal; all inputs are ignored until reset. The HALT instruction does not increment icount.
- Ignored inputs:
  - imem_ack outside FETCH.
  - retire_valid outside EXEC.
  - start outside IDLE.
  - Branch, BranchZero, BranchNonZero and zero when retire_valid=0.

## Timing
- **Reset values:** state=IDLE, imem_req=0, imem_addr=pc=RESET_PC, inst_valid=0, inst=0, halted=0, icount=0. Reset takes effect asynchronously at any point in any state; in-flight acks and retires are dropped.
- All outputs are registered.
- **Cycle sequence:**
  - start sampled in cycle t gives imem_req=1 in cycle t+1.
  - imem_ack in cycle n gives inst_valid=1 in cycle n+1.
  - inst_ready with inst_valid in cycle k gives inst_valid=0 in cycle k+1.
  - retire_valid in cycle m gives imem_req=1 with the new imem_addr, and the updated pc and icount, in cycle m+1.
- **Throughput:** minimum 3 cycles per instruction (ack, ready and retire each on the first possible cycle).
- **HALT:** the handshake in cycle k gives halted=1 in cycle k+1, with imem_req=0 and inst_valid=0 from then on.
- Back-pressure of any length on imem_ack, inst_ready or retire_valid is legal. Outputs must stay unchanged while stalled.

## Structure
- **Shared package cpu_pkg:**
  - opcode constants: OP_HALT=11'h7FF, B prefix 6'b000101, CBZ prefix 8'b10110100, CBNZ prefix 8'b10110101.
  - fetch state enum.
  - immediate field positions: IMM26 = [25:0], IMM19 = [23:5].
- **Sub-module cpu_branch_target:** combinational. Inputs are pc, inst, Branch, BranchZero, BranchNonZero and zero; output is pc_next. It is instantiated once in cpu_fetch and unit-tested separately.

## Test plan
1. **Sequential fetch:** RESET_PC=0, start. Ack 0x8B020020 (ADD); ready; retire with no branch. Expect inst=0x8B020020, then imem_addr=0x4 and icount=1.
2. **Backward branch:** B 0x17FFFFFE (imm26=-2) at pc=0x10; retire with Branch=1. Expect next imem_addr=0x8.
3. **CBZ:** CBZ 0xB4000060 (imm19=3) at pc=0x20. BranchZero=1, zero=1 gives next imem_addr=0x2C; zero=0 gives 0x24. CBNZ 0xB5000060 with zero=1 gives 0x24.
4. **Back-pressure:** hold imem_ack low 4 cycles, then inst_ready low 5 cycles. Expect imem_addr, inst and inst_valid stable throughout, with no duplicate issue.
5. **HALT:** ack 0xFFE00000, ready. Expect halted=1 next cycle. Imem_req stays 0 through 10 cycles of start pulses and spurious acks; icount unchanged.
6. **Reset mid-operation:** assert reset_n=0 while imem_req=1 and imem_ack=1 in the same cycle. Expect immediate reset values, no capture; after release, state=IDLE and pc=RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared LEGv8 fetch definitions: opcode constants, immediate field positions, fetch FSM encoding.
// Pure declarations; no logic, no latency, no flow control.
package cpu_pkg;

  localparam logic [10:0] OP_HALT     = 11'h7FF;
  localparam logic [5:0]  OP_B_PFX    = 6'b000101;
  localparam logic [7:0]  OP_CBZ_PFX  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ_PFX = 8'b10110101;

  localparam int IMM26_MSB = 25;
  localparam int IMM26_LSB = 0;
  localparam int IMM19_MSB = 23;
  localparam int IMM19_LSB = 5;

  typedef logic [2:0] fetch_state_t;
  localparam fetch_state_t ST_IDLE   = 3'd0;
  localparam fetch_state_t ST_FETCH  = 3'd1;
  localparam fetch_state_t ST_ISSUE  = 3'd2;
  localparam fetch_state_t ST_EXEC   = 3'd3;
  localparam fetch_state_t ST_HALTED = 3'd4;

  function automatic logic is_halt(input logic [31:0] word);
    return word[31:21] == OP_HALT;
  endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Fetch unit bus: imem read channel, decode issue handshake and datapath retire/branch feedback.
// Wires only; the fetch unit is the master, memory/decoder/datapath sit on the slave side.
interface cpu_fetch_if #(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            inst_valid;
  logic [31:0]     inst;
  logic            inst_ready;
  logic            retire_valid;
  logic            Branch;
  logic            BranchZero;
  logic            BranchNonZero;
  logic            zero;

  modport master (
    output imem_req, imem_addr, inst_valid, inst,
    input  imem_ack, imem_rdata, inst_ready, retire_valid,
    input  Branch, BranchZero, BranchNonZero, zero
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst,
    output imem_ack, imem_rdata, inst_ready, retire_valid,
    output Branch, BranchZero, BranchNonZero, zero
  );
endinterface

// File: rtl/cpu_branch_target.sv
// Next-PC computation for the retiring instruction: B / CBZ / CBNZ target or fall-through.
// Purely combinational, no flow control; Branch takes priority when several branch controls are set.
module cpu_branch_target
  import cpu_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            Branch,
  input  logic            BranchZero,
  input  logic            BranchNonZero,
  input  logic            zero,
  output logic [PC_W-1:0] pc_next
);

  logic            taken;
  logic [PC_W-1:0] off;
  logic            unused_opcode;

  assign unused_opcode = ^inst[31:26];

  always_comb begin
    taken = Branch | (BranchZero & zero) | (BranchNonZero & ~zero);
    if (Branch) begin
      off = {{(PC_W-26){inst[IMM26_MSB]}}, inst[IMM26_MSB:IMM26_LSB]};
    end else begin
      off = {{(PC_W-19){inst[IMM19_MSB]}}, inst[IMM19_MSB:IMM19_LSB]};
    end
    pc_next = taken ? (pc + (off << 2)) : (pc + PC_W'(4));
  end

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch/sequencer: FETCH -> ISSUE -> EXEC loop, 3 cycles/instr minimum, terminal HALTED.
// All outputs registered; each stage waits indefinitely on ack/ready/retire with outputs held.
module cpu_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  cpu_fetch_if.master      bus,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [31:0]      icount
);

  fetch_state_t    state;
  logic            imem_req_q;
  logic            inst_valid_q;
  logic [31:0]     inst_q;
  logic [PC_W-1:0] pc_next;

  cpu_branch_target #(.PC_W(PC_W)) u_target (
    .pc            (pc),
    .inst          (inst_q),
    .Branch        (bus.Branch),
    .BranchZero    (bus.BranchZero),
    .BranchNonZero (bus.BranchNonZero),
    .zero          (bus.zero),
    .pc_next       (pc_next)
  );

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      pc           <= RESET_PC;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      halted       <= 1'b0;
      icount       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            imem_req_q <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            inst_q       <= bus.imem_rdata;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b1;
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (bus.inst_ready) begin
            inst_valid_q <= 1'b0;
            // HALT is never retired, so icount stays at the last real instruction.
            if (is_halt(inst_q)) begin
              halted <= 1'b1;
              state  <= ST_HALTED;
            end else begin
              state <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          if (bus.retire_valid) begin
            pc         <= pc_next;
            icount     <= icount + 32'd1;
            imem_req_q <= 1'b1;
            state      <= ST_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_fetch.sv
// Self-checking bench for cpu_fetch: directed branch table, back-pressure, HALT, random program, mid-op reset.
module tb_cpu_fetch;
  import cpu_pkg::*;

  localparam int          PC_W = 64;
  localparam logic [63:0] RPC  = 64'h0;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] pc;
  logic        halted;
  logic [31:0] icount;

  cpu_fetch_if #(.PC_W(PC_W)) bus ();

  cpu_fetch #(.PC_W(PC_W), .RESET_PC(RPC)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .bus     (bus),
    .pc      (pc),
    .halted  (halted),
    .icount  (icount)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] m_pc;
  logic [31:0] m_icount;

  typedef struct {
    logic [31:0] w;
    logic        b, bz, bnz, z;
    int          ad, rd, td;
    logic [63:0] exp_next;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference next-PC: signed word offset scaled by 4, plain 64-bit arithmetic.
  function automatic logic [63:0] ref_next(input logic [63:0] p, input logic [31:0] w,
                                           input logic b, input logic bz, input logic bnz,
                                           input logic z);
    longint off;
    bit     take;
    take = b || (bz && z) || (bnz && !z);
    if (!take) return p + 64'd4;
    if (b) begin
      off = longint'(w[25:0]);
      if (w[25]) off = off - (longint'(1) << 26);
    end else begin
      off = longint'(w[23:5]);
      if (w[23]) off = off - (longint'(1) << 19);
    end
    return p + 64'(off * 4);
  endfunction

  task automatic clear_inputs();
    start              = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = '0;
    bus.inst_ready     = 1'b0;
    bus.retire_valid   = 1'b0;
    bus.Branch         = 1'b0;
    bus.BranchZero     = 1'b0;
    bus.BranchNonZero  = 1'b0;
    bus.zero           = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    m_pc     = RPC;
    m_icount = 0;
    chk("rst_pc", pc, RPC);
    chk("rst_addr", bus.imem_addr, RPC);
    chk("rst_req", bus.imem_req, 0);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.inst, 0);
    chk("rst_halted", halted, 0);
    chk("rst_icount", icount, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_req", bus.imem_req, 1);
    chk("start_addr", bus.imem_addr, m_pc);
  endtask

  task automatic run_instr(input logic [31:0] w, input logic b, input logic bz,
                           input logic bnz, input logic z, input int ad, input int rd,
                           input int td);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("req_wait", ok, 1);
    chk("fetch_addr", bus.imem_addr, m_pc);
    // Stray retire/ready while fetching must be ignored.
    repeat (ad) begin
      bus.imem_rdata   = $urandom;
      bus.retire_valid = 1'b1;
      bus.inst_ready   = 1'b1;
      tick();
      chk("stall_addr", bus.imem_addr, m_pc);
      chk("stall_req", bus.imem_req, 1);
      chk("stall_nvalid", bus.inst_valid, 0);
    end
    bus.retire_valid = 1'b0;
    bus.inst_ready   = 1'b0;
    bus.imem_ack     = 1'b1;
    bus.imem_rdata   = w;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    chk("inst", bus.inst, w);
    chk("inst_valid", bus.inst_valid, 1);
    chk("req_drop", bus.imem_req, 0);
    repeat (rd) begin
      bus.imem_ack = 1'b1;
      start        = 1'b1;
      tick();
      chk("hold_inst", bus.inst, w);
      chk("hold_valid", bus.inst_valid, 1);
      chk("hold_nreq", bus.imem_req, 0);
    end
    bus.imem_ack   = 1'b0;
    start          = 1'b0;
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    chk("issue_done", bus.inst_valid, 0);
    if (w[31:21] == OP_HALT) begin
      chk("halt_flag", halted, 1);
      chk("halt_nreq", bus.imem_req, 0);
      return;
    end
    chk("not_halted", halted, 0);
    repeat (td) begin
      bus.Branch        = 1'($urandom);
      bus.BranchZero    = 1'($urandom);
      bus.BranchNonZero = 1'($urandom);
      bus.zero          = 1'($urandom);
      bus.imem_ack      = 1'b1;
      tick();
      chk("exec_pc", pc, m_pc);
      chk("exec_nreq", bus.imem_req, 0);
      chk("exec_nvalid", bus.inst_valid, 0);
      chk("exec_icount", icount, m_icount);
    end
    bus.imem_ack      = 1'b0;
    bus.retire_valid  = 1'b1;
    bus.Branch        = b;
    bus.BranchZero    = bz;
    bus.BranchNonZero = bnz;
    bus.zero          = z;
    tick();
    bus.retire_valid  = 1'b0;
    bus.Branch        = 1'b0;
    bus.BranchZero    = 1'b0;
    bus.BranchNonZero = 1'b0;
    bus.zero          = 1'b0;
    m_pc     = ref_next(m_pc, w, b, bz, bnz, z);
    m_icount = m_icount + 1;
    chk("retire_pc", pc, m_pc);
    chk("retire_addr", bus.imem_addr, m_pc);
    chk("retire_icount", icount, m_icount);
    chk("retire_req", bus.imem_req, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{32'h8B020020, 0, 0, 0, 0, 0, 0, 0, 64'h04};
    tbl[1]  = '{32'h8B020020, 0, 0, 0, 0, 4, 5, 0, 64'h08};
    tbl[2]  = '{32'h8B020020, 0, 0, 0, 0, 0, 0, 3, 64'h0C};
    tbl[3]  = '{32'h8B020020, 0, 0, 0, 0, 1, 1, 1, 64'h10};
    tbl[4]  = '{32'h17FFFFFE, 1, 0, 0, 0, 0, 0, 0, 64'h08};
    tbl[5]  = '{32'h14000006, 1, 0, 0, 0, 0, 0, 0, 64'h20};
    tbl[6]  = '{32'hB4000060, 0, 1, 0, 1, 0, 0, 0, 64'h2C};
    tbl[7]  = '{32'h17FFFFFD, 1, 0, 0, 0, 0, 0, 0, 64'h20};
    tbl[8]  = '{32'hB4000060, 0, 1, 0, 0, 0, 0, 0, 64'h24};
    tbl[9]  = '{32'hB5000060, 0, 0, 1, 1, 0, 0, 0, 64'h28};
    tbl[10] = '{32'h17FFFFFE, 1, 0, 0, 0, 0, 0, 0, 64'h20};
    tbl[11] = '{32'hB5000060, 0, 0, 1, 1, 0, 0, 0, 64'h24};
    tbl[12] = '{32'hB5000060, 0, 0, 1, 0, 0, 0, 0, 64'h30};
    tbl[13] = '{32'h14000002, 1, 1, 0, 1, 0, 0, 0, 64'h38};

    do_reset();
    // Without start the unit must sit in IDLE.
    repeat (3) tick();
    chk("idle_nreq", bus.imem_req, 0);
    do_start();

    for (int i = 0; i < 14; i++) begin
      run_instr(tbl[i].w, tbl[i].b, tbl[i].bz, tbl[i].bnz, tbl[i].z,
                tbl[i].ad, tbl[i].rd, tbl[i].td);
      chk($sformatf("tbl_next[%0d]", i), pc, tbl[i].exp_next);
      chk($sformatf("tbl_icount[%0d]", i), icount, 32'(i + 1));
    end

    run_instr(32'hFFE00000, 0, 0, 0, 0, 1, 2, 0);
    for (int i = 0; i < 10; i++) begin
      start             = 1'b1;
      bus.imem_ack      = 1'b1;
      bus.imem_rdata    = 32'h8B020020;
      bus.inst_ready    = 1'b1;
      bus.retire_valid  = 1'b1;
      bus.Branch        = 1'(i);
      tick();
      chk("halted_req", bus.imem_req, 0);
      chk("halted_valid", bus.inst_valid, 0);
      chk("halted_flag", halted, 1);
      chk("halted_icount", icount, m_icount);
      chk("halted_pc", pc, m_pc);
    end

    do_reset();
    do_start();
    for (int n = 0; n < 150; n++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[31:21] == OP_HALT) w[31] = 1'b0;
      run_instr(w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    // Reset lands while an ack is being presented in FETCH.
    chk("pre_rst_req", bus.imem_req, 1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h8B020020;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_pc", pc, RPC);
    chk("async_req", bus.imem_req, 0);
    chk("async_valid", bus.inst_valid, 0);
    chk("async_inst", bus.inst, 0);
    chk("async_icount", icount, 0);
    tick();
    clear_inputs();
    chk("rst_no_capture", bus.inst, 0);
    reset_n = 1'b1;
    repeat (2) tick();
    m_pc     = RPC;
    m_icount = 0;
    chk("post_rst_idle", bus.imem_req, 0);
    chk("post_rst_pc", pc, RPC);
    chk("post_rst_valid", bus.inst_valid, 0);
    do_start();
    run_instr(32'h8B020020, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
